// File: rtl/line_fill_responder.sv
// ---------------------------------------------------------------------------
// line_fill_responder
//
// Memory-side responder for the cache line-refill interface. When the cache
// raises miss, the line containing cpu_addr is fetched from a backing read
// port one word at a time. Each word is presented to the cache as a single-
// cycle mem_data_valid beat. mem_last marks the final beat of the line.
//
// Ports
//   clk            clock
//   reset          asynchronous, active-high reset
//   cpu_addr       CPU request address (passed through on mem_addr when idle)
//   miss           cache miss, high while the cache is replacing a line
//   mem_addr       address of the current beat (cpu_addr when idle)
//   mem_data_in    refill data word, updated only when a beat is issued
//   mem_wstb       byte strobes, always all ones
//   mem_data_valid one-cycle beat strobe
//   mem_last       final beat of the line (only together with mem_data_valid)
//   bk_req         backing read request, held until bk_gnt
//   bk_addr        backing read address
//   bk_gnt         backing port accepted the request this cycle
//   bk_rvalid      backing read data valid
//   bk_rdata       backing read data
//   busy           a fill is in progress
// ---------------------------------------------------------------------------
module line_fill_responder #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 32,
  parameter int LINE_OFF_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              miss,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [3:0]        mem_wstb,
  output logic              mem_data_valid,
  output logic              mem_last,
  output logic              bk_req,
  output logic [ADDR_W-1:0] bk_addr,
  input  logic              bk_gnt,
  input  logic              bk_rvalid,
  input  logic [DATA_W-1:0] bk_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_BEAT,
    S_DONE
  } state_t;

  state_t                     state_q;
  logic                       miss_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [ADDR_W-LINE_OFF_W-1:0] line_tag_q;
  logic [DATA_W-1:0]          data_q;
  logic                       valid_q;
  logic                       last_q;
  logic                       bk_req_q;

  logic                       start;
  logic [CNT_W-1:0]           cnt_d;
  logic [ADDR_W-LINE_OFF_W-1:0] line_tag_d;
  logic [ADDR_W-1:0]          beat_addr;

  // Only a rising miss seen while idle starts a fill; a miss still high in
  // DONE, or a new edge mid-fill, can therefore never start a second one.
  assign start      = miss & ~miss_q & (state_q == S_IDLE);
  assign cnt_d      = cnt_q + CNT_W'(1);
  assign line_tag_d = cpu_addr[ADDR_W-1:LINE_OFF_W];

  // The beat address is the line base with the word counter placed in the
  // offset field, so it cannot carry out of the line (top-of-memory safe).
  assign beat_addr = {line_tag_q, {LINE_OFF_W{1'b0}}}
                   | ADDR_W'({cnt_q, 2'b00});

  assign mem_addr       = (state_q == S_IDLE) ? cpu_addr : beat_addr;
  assign bk_addr        = beat_addr;
  assign mem_data_in    = data_q;
  assign mem_data_valid = valid_q;
  assign mem_last       = last_q;
  assign mem_wstb       = 4'b1111;
  assign bk_req         = bk_req_q;
  assign busy           = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      miss_q     <= 1'b0;
      cnt_q      <= '0;
      line_tag_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      bk_req_q   <= 1'b0;
    end else begin
      miss_q <= miss;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            line_tag_q <= line_tag_d;
            cnt_q      <= '0;
            bk_req_q   <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bk_gnt) begin
            bk_req_q <= 1'b0;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bk_rvalid) begin
            data_q  <= bk_rdata;
            valid_q <= 1'b1;
            last_q  <= (cnt_q == LAST_CNT);
            state_q <= S_BEAT;
          end
        end
        S_BEAT: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          if (cnt_q == LAST_CNT) begin
            state_q <= S_DONE;
          end else begin
            cnt_q    <= cnt_d;
            bk_req_q <= 1'b1;
            state_q  <= S_FETCH;
          end
        end
        S_DONE: begin
          if (!miss) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/line_fill_responder.md
Name: line_fill_responder

Overview:
Memory-side responder for the cache line-refill interface. It detects a cache miss and fetches the 128-byte line from a backing read port, one word at a time. It streams the line to the cache as 32 single-cycle mem_data_valid beats, with mem_last on the final beat. It sits between the cache's mem_* port and the backing memory/bus read channel.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, word width; fixed at 32 for this interface
WORDS_PER_LINE, 32, beats per refill; power of two
LINE_OFF_W, 7, byte-offset bits per line, log2(WORDS_PER_LINE*DATA_W/8)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cpu_addr  in  ADDR_W  CPU request address, driven to the cache
miss  in  1  cache miss, high while the cache is in REPLACE
mem_addr  out  ADDR_W  address of the current beat
mem_data_in  out  DATA_W  refill data word (cache-side name)
mem_wstb  out  4  byte strobes, constant 4'b1111
mem_data_valid  out  1  beat valid, one-cycle pulse
mem_last  out  1  final beat of the line
bk_req  out  1  backing read request
bk_addr  out  ADDR_W  backing read address
bk_gnt  in  1  request accepted this cycle
bk_rvalid  in  1  read data valid
bk_rdata  in  DATA_W  read data
busy  out  1  fill in progress (state != IDLE)

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0, line_base=0, mem_data_in=0, mem_data_valid=0, mem_last=0, bk_req=0, busy=0. mem_wstb=4'b1111 always.
- mem_addr: equals cpu_addr combinationally in IDLE. In all other states it is the registered beat address.
- miss_q registers miss; start = miss & !miss_q & state==IDLE.
- State machine IDLE -> FETCH -> WAIT -> BEAT -> (FETCH | DONE) -> IDLE.
- IDLE:
  - On start, latch line_base={cpu_addr[ADDR_W-1:LINE_OFF_W], 0}, beat addr=line_base, cnt=0, then go to FETCH.
  - bk_rvalid is ignored.
- FETCH:
  - bk_req=1, bk_addr=beat addr.
  - Hold until bk_gnt. On bk_gnt go to WAIT.
  - bk_rvalid in FETCH is ignored.
- WAIT:
  - bk_req=0.
  - On bk_rvalid, register mem_data_in<=bk_rdata and mem_data_valid<=1, mem_last<=(cnt==WORDS_PER_LINE-1), then go to BEAT.
  - No timeout.
- BEAT (one cycle, valid visible):
  - Next edge: mem_data_valid<=0 and mem_last<=0.
  - If cnt==WORDS_PER_LINE-1, go to DONE. mem_addr is not incremented.
  - Else beat addr+=4, cnt+=1, go to FETCH.
- DONE: wait for miss==0, then go to IDLE. Ignores a still-high miss, so there is no re-trigger.
- Interface invariants:
  - mem_data_in changes only on the edge where mem_data_valid rises.
  - mem_data_valid is never high two consecutive cycles.
  - mem_addr changes only on the edge after a valid beat.
  - mem_last implies mem_data_valid.
  - Beat addresses run line_base+0 ... line_base+124 in order, with no wrap past the line.
- Latency: if bk_gnt is in the first FETCH cycle and bk_rvalid arrives the following cycle:
  - first mem_data_valid is 3 cycles after start;
  - beat period is 3 cycles;
  - full fill takes 96 cycles.
- cnt is a log2(WORDS_PER_LINE)-bit counter. It never wraps within a fill and is cleared on start.
- Top-of-memory line (base 0xFFFFFF80): last beat addr 0xFFFFFFFC, no overflow.
- miss deasserting mid-fill: the fill still completes all beats (no abort). DONE then exits immediately.
- New miss edge during a fill: ignored. Only one fill is ever outstanding.
- Reset mid-fill: immediate return to IDLE with outputs at reset values. A stale bk_rvalid arriving after reset is ignored.

Test Plan:
- Hit-free idle: miss=0, cpu_addr=0x0000_1234 -> mem_addr=0x0000_1234, mem_data_valid=0, busy=0, bk_req=0.
- Basic fill: miss rises with cpu_addr=0x0001_0A48, bk_gnt immediate, bk_rvalid 1 cycle later, bk_rdata=0xAAAAAAAA/0x55555555 alternating. Required response:
  - 32 valid pulses, 3 cycles apart;
  - addresses 0x0001_0A00..0x0001_0A7C;
  - mem_last only on beat 32 (0x0001_0A7C);
  - then IDLE after miss drops.
- Stalled backing: bk_gnt delayed 4 cycles and bk_rvalid delayed 5 cycles per word -> bk_req held high until gnt, no valid pulse until rvalid, mem_data_in stable between beats.
- Top line plus late miss: cpu_addr=0xFFFF_FFF0 -> beats 0xFFFF_FF80..0xFFFF_FFFC, no wrap. Miss held high 10 cycles after mem_last -> stays in DONE, no second fill.
- Reset mid-fill: assert reset after beat 7, with a stale bk_rvalid one cycle after release -> all outputs at reset values, state IDLE, no valid pulse. The next miss starts at beat 0.
- Early miss drop: miss deasserts after beat 3 -> the remaining 29 beats are still delivered, then IDLE one cycle after mem_last.
